plic_claim_engine: RTL and testbench
====================================

Name: plic_claim_engine

Overview:
Hardware interrupt dispatcher that acts as bus initiator toward the PLIC register window. It consumes the PLIC external-interrupt line for one context (M or S), claims by reading the claim register, and hands the source ID to the core through a valid/ready handshake. When the core signals service done, it completes by writing the ID back to the claim register. It sits between the PLIC responder port and the core's trap logic, so the core no longer runs software claim/complete bus cycles.

Parameters:
CLAIM_ADDR, 24'h200004, claim/complete register address (24'h201004 for S context)
ACK_TIMEOUT, 16, max cycles o_stb may wait for i_ack before abort (>=1)
CNT_W, 16, width of serviced-interrupt counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_en  in  1  engine enable; when 0, no new claim starts
i_ext_int  in  1  PLIC external interrupt for this context
o_addr  out  24  bus address
o_we  out  4  bus byte write enables
o_dat_w  out  32  bus write data
i_dat_r  in  32  bus read data
o_stb  out  1  bus strobe
i_ack  in  1  bus acknowledge; may be combinational from o_stb
o_irq_valid  out  1  claimed ID available to core
o_irq_id  out  5  claimed source ID (1..31)
i_irq_ready  in  1  core accepts ID
i_irq_done  in  1  core finished servicing (one-cycle pulse)
o_busy  out  1  state != IDLE
o_err  out  1  sticky bus-timeout flag
i_err_clr  in  1  clears o_err
o_count  out  CNT_W  number of completed interrupts, wraps

Behaviour:
- Reset: all outputs 0 (o_addr/o_we/o_dat_w/o_stb/o_irq_valid/o_irq_id/o_busy/o_err/o_count); state IDLE; ID register 0; timeout counter 0.
- Bus rule: o_stb is held with stable o_addr/o_we/o_dat_w until i_ack=1 is sampled. o_stb drops in the cycle after the ack edge. Read data is captured on the edge where o_stb&i_ack. With zero-wait ack, each access occupies exactly one o_stb cycle.
- o_addr = CLAIM_ADDR while o_stb=1, else 0. Reads use o_we=0. The complete write uses o_we=4'b0001 and o_dat_w={27'd0,id}. o_dat_w=0 otherwise.
- FSM states:
  - IDLE: when i_en & i_ext_int -> CLAIM_RD, asserting o_stb next cycle.
  - CLAIM_RD: on ack, id <= i_dat_r[4:0]. If i_dat_r[4:0]==0 (spurious) -> SETTLE with no dispatch; else -> DISPATCH.
  - DISPATCH: o_irq_valid=1 with o_irq_id=id. When i_irq_ready=1 -> SERVICE. o_irq_valid drops the next cycle.
  - SERVICE: wait for i_irq_done -> COMPLETE_WR. An i_irq_done outside SERVICE is ignored.
  - COMPLETE_WR: on ack -> SETTLE and o_count <= o_count+1 (mod 2^CNT_W).
  - SETTLE: exactly one cycle, so the PLIC pending update propagates to i_ext_int. Then -> IDLE. The same ID is never reclaimed from stale i_ext_int.
- Timeout: counter runs while o_stb=1 and i_ack=0. On reaching ACK_TIMEOUT, drop o_stb, set o_err, and -> IDLE. A timeout in COMPLETE_WR does not increment o_count. Counter clears on every ack or state change.
- o_err: set by timeout, cleared by i_err_clr. Set wins if both occur in the same cycle.
- i_en deassert mid-sequence does not abort; the current claim runs to SETTLE.
- i_rst mid-transaction: o_stb drops on the reset edge and state returns to IDLE. A pending complete is lost by design; the PLIC is reset alongside.
- i_irq_ready and i_irq_done in the same DISPATCH cycle: only ready is honoured, and done is required again in SERVICE.
- Latency with zero-wait ack: i_ext_int rise to o_irq_valid = 3 cycles (IDLE decision, CLAIM_RD strobe, DISPATCH).

Decomposition:
- Shared package: FSM state encoding (6 states, 3 bits), address constants CLAIM_M_ADDR=24'h200004 and CLAIM_S_ADDR=24'h201004, byte-enable constant WE_BYTE0.
- One natural sub-module: bus_master_port, which holds o_stb/o_addr/o_we/o_dat_w, runs the timeout counter, and returns done/timeout/rdata to the FSM.

Test Plan:
- Zero-wait bus, ext_int=1, claim reads 5 -> o_stb one cycle at 24'h200004 with o_we=0. o_irq_valid=1 with id=5 three cycles after ext_int; ready then done -> write o_we=1, o_dat_w=5, o_count=1; one SETTLE cycle, then IDLE.
- Claim read returns 0 -> no o_irq_valid, no write cycle, o_count unchanged, back to IDLE after SETTLE.
- Ack delayed 3 cycles on both accesses -> o_stb/o_addr held stable 4 cycles each; id captured only on the ack edge.
- Never ack with ACK_TIMEOUT=16 -> o_stb drops after 16 cycles, o_err=1, IDLE. i_err_clr pulse -> o_err=0.
- ext_int held high across two sources (IDs 3 then 7 pending) -> two back-to-back claim/complete sequences in order 3 then 7, each separated by SETTLE, o_count=2.
- Reset asserted during SERVICE -> all outputs 0 the next cycle, state IDLE; a later done pulse is ignored.

Source files
------------

// File: rtl/plic_claim_engine_pkg.sv
// Shared types and constants for the PLIC claim/complete engine.
// Holds FSM encoding, claim register addresses and bus write enables.
package plic_claim_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CLAIM_RD    = 3'd1,
    ST_DISPATCH    = 3'd2,
    ST_SERVICE     = 3'd3,
    ST_COMPLETE_WR = 3'd4,
    ST_SETTLE      = 3'd5
  } state_t;

  localparam logic [23:0] CLAIM_M_ADDR = 24'h200004;
  localparam logic [23:0] CLAIM_S_ADDR = 24'h201004;

  localparam logic [3:0] WE_BYTE0 = 4'b0001;
  localparam logic [3:0] WE_NONE  = 4'b0000;

  localparam int ID_W = 5;

  // Complete write carries the source ID in the low byte.
  function automatic logic [31:0] complete_word(
    input logic [ID_W-1:0] id
  );
    return {{(32-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/plic_claim_engine_bus_master_port.sv
// Single-outstanding bus initiator toward the PLIC claim register.
// Ports: start/write/wdata from FSM; addr/we/dat_w/stb/ack/dat_r bus;
// done/timeout/rdata back to FSM.
module plic_claim_engine_bus_master_port
  import plic_claim_engine_pkg::*;
#(
  parameter logic [23:0] ADDR        = CLAIM_M_ADDR,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            write,
  input  logic [31:0]     wdata,
  input  logic            ack,
  input  logic [31:0]     dat_r,
  output logic [23:0]     addr,
  output logic [3:0]      we,
  output logic [31:0]     dat_w,
  output logic            stb,
  output logic            done,
  output logic            timeout,
  output logic [ID_W-1:0] rdata
);

  localparam int TW =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic          stb_q;
  logic [3:0]    we_q;
  logic [31:0]   dat_q;
  logic [TW-1:0] cnt;
  logic          unused_hi;

  assign done    = stb_q & ack;
  // Fires in the last allowed wait cycle, so stb is high
  // for exactly ACK_TIMEOUT cycles when no ack arrives.
  assign timeout = stb_q & ~ack
                 & (cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b0;
      we_q  <= WE_NONE;
      dat_q <= '0;
      cnt   <= '0;
    end else if (start) begin
      stb_q <= 1'b1;
      we_q  <= write ? WE_BYTE0 : WE_NONE;
      dat_q <= write ? wdata : '0;
      cnt   <= '0;
    end else if (done | timeout) begin
      stb_q <= 1'b0;
      we_q  <= WE_NONE;
      dat_q <= '0;
      cnt   <= '0;
    end else if (stb_q) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign stb   = stb_q;
  assign addr  = stb_q ? ADDR : '0;
  assign we    = we_q;
  assign dat_w = dat_q;
  assign rdata = dat_r[ID_W-1:0];

  assign unused_hi = ^dat_r[31:ID_W];

endmodule

// File: rtl/plic_claim_engine.sv
// Hardware claim/complete dispatcher for one PLIC context.
// Ports: i_clk/i_rst, i_en/i_ext_int, bus (o_addr..i_ack),
// core handshake (o_irq_*, i_irq_*), status (o_busy/o_err/o_count).
module plic_claim_engine
  import plic_claim_engine_pkg::*;
#(
  parameter logic [23:0] CLAIM_ADDR  = CLAIM_M_ADDR,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_ext_int,
  output logic [23:0]      o_addr,
  output logic [3:0]       o_we,
  output logic [31:0]      o_dat_w,
  input  logic [31:0]      i_dat_r,
  output logic             o_stb,
  input  logic             i_ack,
  output logic             o_irq_valid,
  output logic [4:0]       o_irq_id,
  input  logic             i_irq_ready,
  input  logic             i_irq_done,
  output logic             o_busy,
  output logic             o_err,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_count
);

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic            bus_start;
  logic            bus_write;
  logic            bus_done;
  logic            bus_timeout;
  logic [ID_W-1:0] bus_rdata;

  logic ld_id;
  logic inc_cnt;
  logic irq_valid;
  logic busy;

  plic_claim_engine_bus_master_port #(
    .ADDR        (CLAIM_ADDR),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_bus (
    .clk     (i_clk),
    .rst     (i_rst),
    .start   (bus_start),
    .write   (bus_write),
    .wdata   (complete_word(id_q)),
    .ack     (i_ack),
    .dat_r   (i_dat_r),
    .addr    (o_addr),
    .we      (o_we),
    .dat_w   (o_dat_w),
    .stb     (o_stb),
    .done    (bus_done),
    .timeout (bus_timeout),
    .rdata   (bus_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (i_en & i_ext_int) state_nxt = ST_CLAIM_RD;
      end
      ST_CLAIM_RD: begin
        if (bus_timeout) begin
          state_nxt = ST_IDLE;
        end else if (bus_done) begin
          // A zero ID is a spurious claim: nothing to dispatch.
          state_nxt = (bus_rdata == '0) ? ST_SETTLE
                                        : ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (i_irq_ready) state_nxt = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (i_irq_done) state_nxt = ST_COMPLETE_WR;
      end
      ST_COMPLETE_WR: begin
        if (bus_timeout)   state_nxt = ST_IDLE;
        else if (bus_done) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_start = 1'b0;
    bus_write = 1'b0;
    ld_id     = 1'b0;
    inc_cnt   = 1'b0;
    irq_valid = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (1'b1)
      (state == ST_IDLE): begin
        bus_start = i_en & i_ext_int;
      end
      (state == ST_CLAIM_RD): begin
        ld_id = bus_done;
      end
      (state == ST_DISPATCH): begin
        irq_valid = 1'b1;
      end
      (state == ST_SERVICE): begin
        bus_start = i_irq_done;
        bus_write = i_irq_done;
      end
      (state == ST_COMPLETE_WR): begin
        inc_cnt = bus_done;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      id_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (ld_id)   id_q  <= bus_rdata;
      if (inc_cnt) cnt_q <= cnt_q + CNT_W'(1);
      // Timeout takes priority over a simultaneous clear.
      if (bus_timeout)    err_q <= 1'b1;
      else if (i_err_clr) err_q <= 1'b0;
    end
  end

  assign o_irq_valid = irq_valid;
  assign o_irq_id    = id_q;
  assign o_busy      = busy;
  assign o_err       = err_q;
  assign o_count     = cnt_q;

endmodule

// File: tb/tb_plic_claim_engine.sv
// Self-checking bench for plic_claim_engine.
// PLIC responder model with pending-ID queue, delay and no-ack modes.
module tb_plic_claim_engine;
  import plic_claim_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        ext_int;
  logic [23:0] addr;
  logic [3:0]  we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        stb;
  logic        ack;
  logic        irq_valid;
  logic [4:0]  irq_id;
  logic        rdy = 1'b0;
  logic        done = 1'b0;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;
  logic [15:0] count;

  always #5 clk = ~clk;

  plic_claim_engine dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_ext_int   (ext_int),
    .o_addr      (addr),
    .o_we        (we),
    .o_dat_w     (dat_w),
    .i_dat_r     (dat_r),
    .o_stb       (stb),
    .i_ack       (ack),
    .o_irq_valid (irq_valid),
    .o_irq_id    (irq_id),
    .i_irq_ready (rdy),
    .i_irq_done  (done),
    .o_busy      (busy),
    .o_err       (err),
    .i_err_clr   (err_clr),
    .o_count     (count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // PLIC responder model
  logic [4:0] pend [0:7];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic       ext_manual = 1'b0;
  int         ack_delay = 0;
  logic       no_ack = 1'b0;
  int         wcnt = 0;
  logic [31:0] wr_log [0:31];
  int          n_wr = 0;

  assign ext_int = ext_manual | (rd_ptr != wr_ptr);
  assign ack = stb && !no_ack && (wcnt == ack_delay);
  assign dat_r = !ack ? 32'hDEAD_BEEF :
                 (rd_ptr != wr_ptr) ?
                 {27'd0, pend[rd_ptr[2:0]]} : 32'd0;

  always @(posedge clk) begin
    if (!stb || ack) wcnt <= 0;
    else             wcnt <= wcnt + 1;
    if (stb && ack && we == 4'd0 && rd_ptr != wr_ptr)
      rd_ptr <= rd_ptr + 1;
    if (stb && ack && we != 4'd0) begin
      wr_log[n_wr[4:0]] <= dat_w;
      n_wr <= n_wr + 1;
    end
  end

  // Access monitor, sampled on the falling edge
  int          cyc = 0;
  int          n_acc = 0;
  int          acc_start [0:63];
  int          acc_len [0:63];
  logic [3:0]  acc_we [0:63];
  int          run = 0;
  logic [3:0]  first_we;
  logic [31:0] first_dat;
  int          addr_bad = 0;
  int          stable_bad = 0;
  int          idle_bad = 0;
  int          valid_cnt = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (stb) begin
      if (run == 0) begin
        acc_start[n_acc[5:0]] <= cyc;
        acc_we[n_acc[5:0]] <= we;
        first_we <= we;
        first_dat <= dat_w;
      end else if (we != first_we || dat_w != first_dat) begin
        stable_bad <= stable_bad + 1;
      end
      run <= run + 1;
      if (addr != CLAIM_M_ADDR) addr_bad <= addr_bad + 1;
    end else begin
      if (addr != 24'd0 || we != 4'd0 || dat_w != 32'd0)
        idle_bad <= idle_bad + 1;
      if (run != 0) begin
        acc_len[n_acc[5:0]] <= run;
        n_acc <= n_acc + 1;
        run <= 0;
      end
    end
    if (irq_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic push(logic [4:0] v);
    pend[wr_ptr[2:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(string nm);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (irq_valid) break;
    end
    chk(nm, irq_valid, 1);
  endtask

  task automatic serve();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  push;
    logic        rdy;
    logic        done;
    logic        stb;
    logic [3:0]  we;
    logic [31:0] dat;
    logic        valid;
    logic [4:0]  id;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv [0:6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int na0, nw0, vc0, early;
    logic [15:0] c0;
    logic [4:0]  got [0:1];

    tv[0] = '{5'd5, 0, 0, 0, 4'd0, 32'd0, 0, 5'd0, 0, 16'd0};
    tv[1] = '{5'd0, 0, 0, 1, 4'd0, 32'd0, 0, 5'd0, 1, 16'd0};
    tv[2] = '{5'd0, 1, 0, 0, 4'd0, 32'd0, 1, 5'd5, 1, 16'd0};
    tv[3] = '{5'd0, 0, 1, 0, 4'd0, 32'd0, 0, 5'd5, 1, 16'd0};
    tv[4] = '{5'd0, 0, 0, 1, 4'd1, 32'd5, 0, 5'd5, 1, 16'd0};
    tv[5] = '{5'd0, 0, 0, 0, 4'd0, 32'd0, 0, 5'd5, 1, 16'd1};
    tv[6] = '{5'd0, 0, 0, 0, 4'd0, 32'd0, 0, 5'd5, 0, 16'd1};

    // Reset state
    step(3);
    #1;
    chk("rst_stb", stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", irq_valid, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_bus", {addr, we}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic claim/dispatch/complete trace
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (tv[i].push != 5'd0) push(tv[i].push);
      rdy = tv[i].rdy;
      done = tv[i].done;
      #1;
      chk($sformatf("tv%0d_stb", i), stb, tv[i].stb);
      chk($sformatf("tv%0d_addr", i), addr,
          tv[i].stb ? CLAIM_M_ADDR : 24'd0);
      chk($sformatf("tv%0d_we", i), we, tv[i].we);
      chk($sformatf("tv%0d_dat", i), dat_w, tv[i].dat);
      chk($sformatf("tv%0d_valid", i), irq_valid, tv[i].valid);
      chk($sformatf("tv%0d_id", i), irq_id, tv[i].id);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("tv%0d_cnt", i), count, tv[i].cnt);
    end
    rdy = 1'b0;
    done = 1'b0;
    step(2);

    // Spurious claim (ID 0)
    na0 = n_acc; nw0 = n_wr; vc0 = valid_cnt; c0 = count;
    @(negedge clk);
    ext_manual = 1'b1;
    @(negedge clk);
    ext_manual = 1'b0;
    step(6);
    #1;
    chk("spur_reads", n_acc - na0, 1);
    chk("spur_valid", valid_cnt - vc0, 0);
    chk("spur_writes", n_wr - nw0, 0);
    chk("spur_count", count, c0);
    chk("spur_busy", busy, 0);
    chk("spur_id", irq_id, 0);

    // Ack delayed three cycles on both accesses
    ack_delay = 3;
    na0 = n_acc; nw0 = n_wr; c0 = count;
    early = 0;
    @(negedge clk);
    push(5'd9);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (stb && we == 4'd0 && irq_id != 5'd0) early++;
      if (irq_valid) break;
    end
    chk("dly_valid", irq_valid, 1);
    chk("dly_id", irq_id, 9);
    chk("dly_early_id", early, 0);
    serve();
    step(10);
    chk("dly_rd_len", acc_len[na0], 4);
    chk("dly_wr_len", acc_len[na0+1], 4);
    chk("dly_wr_we", acc_we[na0+1], 1);
    chk("dly_wr_dat", wr_log[nw0], 9);
    chk("dly_count", count, c0 + 16'd1);
    ack_delay = 0;

    // Ready and done together in DISPATCH
    nw0 = n_wr; c0 = count;
    @(negedge clk);
    push(5'd2);
    wait_valid("rd_valid");
    rdy = 1'b1;
    done = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    done = 1'b0;
    #1;
    chk("rd_service_busy", busy, 1);
    step(2);
    #1;
    chk("rd_no_write", stb, 0);
    chk("rd_still_busy", busy, 1);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    #1;
    chk("rd_wr_stb", stb, 1);
    chk("rd_wr_dat", dat_w, 2);
    step(4);
    chk("rd_count", count, c0 + 16'd1);
    chk("rd_writes", n_wr - nw0, 1);

    // Two sources pending back to back: 3 then 7
    na0 = n_acc; nw0 = n_wr; c0 = count;
    @(negedge clk);
    push(5'd3);
    push(5'd7);
    for (int k = 0; k < 2; k++) begin
      wait_valid($sformatf("two_valid%0d", k));
      got[k] = irq_id;
      serve();
    end
    step(8);
    chk("two_id0", got[0], 3);
    chk("two_id1", got[1], 7);
    chk("two_wr0", wr_log[nw0[4:0]], 3);
    chk("two_wr1", wr_log[nw0[4:0]+5'd1], 7);
    chk("two_count", count, c0 + 16'd2);
    chk("two_gap", acc_start[na0+2]
        - (acc_start[na0+1] + acc_len[na0+1]), 2);
    chk("two_busy", busy, 0);

    // Bus never acks
    no_ack = 1'b1;
    na0 = n_acc; c0 = count;
    @(negedge clk);
    push(5'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stb) break;
    end
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stb) break;
    end
    @(negedge clk);
    #1;
    chk("to_len", acc_len[na0], 16);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_count", count, c0);
    wr_ptr = rd_ptr;
    no_ack = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("to_err_clr", err, 0);
    en = 1'b1;

    // Reset while in SERVICE
    nw0 = n_wr;
    @(negedge clk);
    push(5'd6);
    wait_valid("rs_valid");
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    #1;
    chk("rs_in_service", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_stb", stb, 0);
    chk("rs_count", count, 0);
    chk("rs_id", irq_id, 0);
    chk("rs_valid", irq_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    step(3);
    #1;
    chk("rs_done_ignored", busy, 0);
    chk("rs_no_write", n_wr - nw0, 0);

    chk("addr_stable", addr_bad, 0);
    chk("bus_stable", stable_bad, 0);
    chk("bus_idle_zero", idle_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
